// File: rtl/plab1_imul_int_mul_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : plab1_imul_int_mul_div_iter
//  Description : Iterative 32-bit integer multiply/divide responder sitting on
//                a val/rdy request/response channel. It computes MUL, DIV,
//                DIVU, REM and REMU one operation at a time: shift-add for
//                multiplies, and restoring division on magnitudes followed by
//                a single sign-fix cycle for divides.
//  Revision    : 1.0 - initial release
// ============================================================================
module plab1_imul_int_mul_div_iter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [66:0] in_msg,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_msg
);

    localparam logic [2:0] c_FUNC_MUL  = 3'd0;
    localparam logic [2:0] c_FUNC_DIV  = 3'd1;
    localparam logic [2:0] c_FUNC_DIVU = 3'd2;
    localparam logic [2:0] c_FUNC_REM  = 3'd3;
    localparam logic [2:0] c_FUNC_REMU = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q,   state_d;
    logic [2:0]  func_q,    func_d;
    logic [31:0] a_q,       a_d;       // multiplicand, or dividend/quotient shifter
    logic [31:0] b_q,       b_d;       // multiplier, or divisor magnitude
    logic [31:0] result_q,  result_d;  // product accumulator and response value
    logic [31:0] rem_q,     rem_d;     // partial remainder
    logic [4:0]  cnt_q,     cnt_d;     // quotient bit index
    logic        neg_a_q,   neg_a_d;   // original operand signs for the fix step
    logic        neg_b_q,   neg_b_d;
    logic        out_val_q, out_val_d;

    logic [2:0]  w_req_func;
    logic [31:0] w_req_a;
    logic [31:0] w_req_b;
    logic [31:0] w_req_a_mag;
    logic [31:0] w_req_b_mag;
    logic        w_in_fire;
    logic [32:0] w_div_trial;
    logic [32:0] w_div_diff;

    assign w_req_func  = in_msg[66:64];
    assign w_req_a     = in_msg[63:32];
    assign w_req_b     = in_msg[31:0];
    assign w_req_a_mag = w_req_a[31] ? (~w_req_a + 32'd1) : w_req_a;
    assign w_req_b_mag = w_req_b[31] ? (~w_req_b + 32'd1) : w_req_b;

    assign in_rdy    = (state_q == S_IDLE) && reset_n;
    assign w_in_fire = in_val && in_rdy;
    assign out_val   = out_val_q;
    assign out_msg   = result_q;

    // One restoring step: shift the next dividend bit into the remainder and
    // try to subtract the divisor; a clear borrow bit means the step succeeded.
    assign w_div_trial = {rem_q, a_q[31]};
    assign w_div_diff  = w_div_trial - {1'b0, b_q};

    // Next-state and datapath update for every state of the operation.
    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        out_val_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_in_fire) begin
                    func_d  = w_req_func;
                    a_d     = w_req_a;
                    b_d     = w_req_b;
                    neg_a_d = w_req_a[31];
                    neg_b_d = w_req_b[31];
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    case (w_req_func)
                        c_FUNC_MUL: begin
                            result_d = 32'd0;
                            state_d  = S_MUL;
                        end
                        c_FUNC_DIV, c_FUNC_DIVU, c_FUNC_REM, c_FUNC_REMU: begin
                            if (w_req_b == 32'd0) begin
                                // Divide by zero answers immediately: all ones
                                // for a quotient, the dividend for a remainder.
                                state_d = S_DONE;
                                if ((w_req_func == c_FUNC_DIV) || (w_req_func == c_FUNC_DIVU)) begin
                                    result_d = 32'hFFFF_FFFF;
                                end else begin
                                    result_d = w_req_a;
                                end
                            end else begin
                                state_d = S_DIV;
                                if ((w_req_func == c_FUNC_DIV) || (w_req_func == c_FUNC_REM)) begin
                                    a_d = w_req_a_mag;
                                    b_d = w_req_b_mag;
                                end
                            end
                        end
                        default: begin
                            result_d = 32'd0;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end

            S_MUL: begin
                if (b_q == 32'd0) begin
                    state_d = S_DONE;
                end else begin
                    if (b_q[0]) begin
                        result_d = result_q + a_q;
                    end
                    a_d = {a_q[30:0], 1'b0};
                    b_d = {1'b0, b_q[31:1]};
                end
            end

            S_DIV: begin
                if (!w_div_diff[32]) begin
                    rem_d = w_div_diff[31:0];
                    a_d   = {a_q[30:0], 1'b1};
                end else begin
                    rem_d = w_div_trial[31:0];
                    a_d   = {a_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // a_q now holds the quotient magnitude, rem_q the remainder.
                case (func_q)
                    c_FUNC_DIV:  result_d = (neg_a_q ^ neg_b_q) ? (~a_q + 32'd1) : a_q;
                    c_FUNC_DIVU: result_d = a_q;
                    c_FUNC_REM:  result_d = neg_a_q ? (~rem_q + 32'd1) : rem_q;
                    default:     result_d = rem_q;
                endcase
                state_d = S_DONE;
            end

            S_DONE: begin
                // The response is presented from the cycle after entry and is
                // held until the consumer takes it.
                out_val_d = 1'b1;
                if (out_val_q && out_rdy) begin
                    out_val_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            func_q    <= 3'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            result_q  <= 32'd0;
            rem_q     <= 32'd0;
            cnt_q     <= 5'd0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            out_val_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            out_val_q <= out_val_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plab1_imul_int_mul_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plab1_imul_int_mul_div_iter
//  Description : Self-checking bench for the iterative multiply/divide unit.
//                An arithmetic reference model predicts each response value
//                and its arrival cycle; a negedge monitor compares the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plab1_imul_int_mul_div_iter;

    localparam logic [2:0] c_MUL  = 3'd0;
    localparam logic [2:0] c_DIV  = 3'd1;
    localparam logic [2:0] c_DIVU = 3'd2;
    localparam logic [2:0] c_REM  = 3'd3;
    localparam logic [2:0] c_REMU = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_val;
    logic        in_rdy;
    logic [66:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;

    plab1_imul_int_mul_div_iter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain arithmetic on the operands.
    // ------------------------------------------------------------------
    function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'd0;
        case (f)
            c_MUL:  r = {32'd0, a} * {32'd0, b};
            c_DIV:  r = (b == 32'd0) ? 64'hFFFF_FFFF : 64'(sa / sb);
            c_DIVU: r = (b == 32'd0) ? 64'hFFFF_FFFF : {32'd0, a / b};
            c_REM:  r = (b == 32'd0) ? {32'd0, a} : 64'(sa % sb);
            c_REMU: r = (b == 32'd0) ? {32'd0, a} : {32'd0, a % b};
            default: r = 64'd0;
        endcase
        return r[31:0];
    endfunction

    // Edges from accept until out_val is first visible.
    function automatic int model_lat(input logic [2:0] f, input logic [31:0] b);
        int k;
        k = -1;
        for (int i = 0; i < 32; i++) if (b[i]) k = i;
        if (f == c_MUL)  return (k < 0) ? 2 : 3 + k;
        if (f <= c_REMU) return (b == 32'd0) ? 1 : 34;
        return 1;
    endfunction

    typedef struct {
        logic [31:0] res;
        int          t;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        seen     = 1'b0;
    logic        late     = 1'b0;
    logic [31:0] last_res = 32'd0;
    int          last_lat = 0;
    int          pop_edge = 0;
    int          push_edge = 0;
    int          n_resp   = 0;

    // Compare process: response value, arrival cycle, busy in_rdy and
    // one-outstanding behaviour, sampled between rising edges.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            seen = 1'b0;
            late = 1'b0;
        end else begin
            if (out_val) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_val", 64'(out_val), 64'(0));
                end else begin
                    if (!seen) begin
                        last_lat = cyc - exp_q[0].t;
                        check("latency", 64'(last_lat), 64'(exp_q[0].due - exp_q[0].t));
                        seen = 1'b1;
                    end
                    last_res = out_msg;
                    check("out_msg", 64'(out_msg), 64'(exp_q[0].res));
                    check("in_rdy_while_busy", 64'(in_rdy), 64'(0));
                    if (out_rdy) begin
                        void'(exp_q.pop_front());
                        seen     = 1'b0;
                        late     = 1'b0;
                        pop_edge = cyc + 1;
                        n_resp++;
                    end
                end
            end else if ((exp_q.size() > 0) && !late && (cyc > exp_q[0].due)) begin
                check("late_response", 64'(out_val), 64'(1));
                late = 1'b1;
            end
            if (in_val && in_rdy) begin
                check("one_outstanding", 64'(exp_q.size()), 64'(0));
                mon_e.res = model_res(in_msg[66:64], in_msg[63:32], in_msg[31:0]);
                mon_e.t   = cyc + 1;
                mon_e.due = cyc + 1 + model_lat(in_msg[66:64], in_msg[31:0]);
                exp_q.push_back(mon_e);
                push_edge = cyc + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (all called and returning at posedge + 1).
    // ------------------------------------------------------------------
    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        in_msg = {f, a, b};
        in_val = 1'b1;
        for (n = 0; n < 200 && !in_rdy; n++) begin
            @(posedge clk); #1;
        end
        check("send_in_rdy", 64'(in_rdy), 64'(1));
        @(posedge clk); #1;
        in_val = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!((exp_q.size() == 0) && in_rdy) && (n < 200)) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_done", 64'({exp_q.size() == 0, in_rdy}), 64'(2'b11));
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        send(f, a, b);
        wait_done();
    endtask

    task automatic pin(input string name, input logic [31:0] res, input int lat);
        check({name, "_res"}, 64'(last_res), 64'(res));
        check({name, "_lat"}, 64'(last_lat), 64'(lat));
    endtask

    logic [2:0]  v_f [8] = '{c_REM,  c_DIV,  c_REMU, c_DIVU, c_DIV,  c_REM,        c_MUL,         c_REM};
    logic [31:0] v_a [8] = '{32'd7,  32'd7,  32'd100, 32'd100, 32'd0, 32'hFFFF_FFF8, 32'h1234_5678, 32'hFFFF_FFFB};
    logic [31:0] v_b [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd7, 32'd7, 32'd5, 32'hFFFF_FFFD, 32'h9ABC_DEF0, 32'd0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_before;

        reset_n = 1'b1;
        in_val  = 1'b0;
        in_msg  = '0;
        out_rdy = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_val", 64'(out_val), 64'(0));
        check("rst_in_rdy",  64'(in_rdy),  64'(0));
        check("rst_out_msg", 64'(out_msg), 64'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_rdy_after_reset", 64'(in_rdy), 64'(1));

        // Multiply
        run(c_MUL, 32'd3, 32'd5);
        pin("mul_3x5", 32'd15, 5);
        check("mul_in_rdy_next_cycle", 64'(cyc), 64'(pop_edge));
        run(c_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        pin("mul_ones", 32'h0000_0001, 34);
        run(c_MUL, 32'd7, 32'd0);
        pin("mul_by_zero", 32'd0, 2);

        // Division
        run(c_DIV, 32'hFFFF_FFF9, 32'd2);
        pin("div_m7_2", 32'hFFFF_FFFD, 34);
        run(c_REM, 32'hFFFF_FFF9, 32'd2);
        pin("rem_m7_2", 32'hFFFF_FFFF, 34);
        run(c_DIVU, 32'hFFFF_FFF9, 32'd2);
        pin("divu_big", 32'h7FFF_FFFC, 34);
        run(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        pin("div_overflow", 32'h8000_0000, 34);
        run(c_DIV, 32'd5, 32'd0);
        pin("div_by_zero", 32'hFFFF_FFFF, 1);
        run(c_REMU, 32'd5, 32'd0);
        pin("remu_by_zero", 32'd5, 1);
        run(3'd6, 32'd9, 32'd3);
        pin("unsupported", 32'd0, 1);

        // Further vectors checked only against the model
        for (int i = 0; i < 8; i++) run(v_f[i], v_a[i], v_b[i]);

        // Back-pressure: response held, new request refused until handshake
        out_rdy = 1'b0;
        send(c_DIVU, 32'd1000, 32'd7);
        for (n = 0; n < 100 && !out_val; n++) begin
            @(posedge clk); #1;
        end
        check("bp_out_val_rose", 64'(out_val), 64'(1));
        n_before = n_resp;
        in_msg   = {c_MUL, 32'd6, 32'd7};
        in_val   = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("bp_out_val_held", 64'(out_val), 64'(1));
        check("bp_in_rdy_low",   64'(in_rdy),  64'(0));
        check("bp_out_msg",      64'(out_msg), 64'(142));
        check("bp_no_delivery",  64'(n_resp),  64'(n_before));
        out_rdy = 1'b1;
        for (n = 0; n < 20 && !in_rdy; n++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_val = 1'b0;
        check("bp_one_delivery",   64'(n_resp),    64'(n_before + 1));
        check("bp_accept_spacing", 64'(push_edge), 64'(pop_edge + 1));
        wait_done();
        pin("bp_mul", 32'd42, 5);

        // Reset in the middle of a divide
        send(c_DIV, 32'd100, 32'd3);
        repeat (9) begin
            @(posedge clk); #1;
        end
        n_before = n_resp;
        reset_n  = 1'b0;
        #1;
        check("midrst_out_val", 64'(out_val), 64'(0));
        check("midrst_in_rdy",  64'(in_rdy),  64'(0));
        check("midrst_out_msg", 64'(out_msg), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_rdy_after", 64'(in_rdy), 64'(1));
        check("midrst_no_response",  64'(n_resp), 64'(n_before));
        run(c_MUL, 32'd2, 32'd2);
        pin("mul_after_reset", 32'd4, 4);

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
